// File: rtl/i2c_reg_seq.sv
// Register-access sequencer for a byte-level I2C master: expands one register
// read/write request into START/address/pointer/data/STOP byte commands and returns one response.
//
// state      | meaning
// IDLE       | ready for a request (req_ready_o high)
// ISSUE      | presenting the current step's byte command to the master
// WAIT       | byte in flight; waiting for m_done_i or the per-byte timeout
// ABORT      | presenting a STOP-only command after a NACK or timeout
// ABORT_WAIT | STOP in flight; waiting for m_done_i or the timeout
// RESP       | one-cycle response pulse
module i2c_reg_seq #(
  parameter int DEV_ADDR_WIDTH = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int TMO_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      s_rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_rnw_i,
  input  logic [DEV_ADDR_WIDTH-1:0] req_dev_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_reg_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [TMO_WIDTH-1:0]      timeout_i,
  output logic                      rsp_valid_o,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic [1:0]                rsp_err_o,
  output logic                      m_cmd_valid_o,
  input  logic                      m_cmd_ready_i,
  output logic [1:0]                m_cmd_op_o,
  output logic                      m_cmd_start_o,
  output logic                      m_cmd_stop_o,
  output logic [DATA_WIDTH-1:0]     m_cmd_data_o,
  input  logic                      m_done_i,
  input  logic                      m_ack_i,
  input  logic [DATA_WIDTH-1:0]     m_rdata_i
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ABORT,
    ABORT_WAIT,
    RESP
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              step, step_nxt;
  logic                    rnw_q;
  logic [DEV_ADDR_WIDTH-1:0] dev_q;
  logic [DATA_WIDTH-1:0]   reg_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_nxt;
  logic [1:0]              err_q, err_nxt;
  logic [TMO_WIDTH-1:0]    cnt_q, cnt_nxt, cnt_inc;
  logic                    ready_q;
  logic [1:0]              rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    accept;
  logic                    last_step;
  logic                    tmo_hit;
  logic [1:0]              step_op;
  logic                    step_start;
  logic                    step_stop;
  logic [DATA_WIDTH-1:0]   step_data;

  // Byte command for the current step; the address byte carries R/W in its LSB.
  always_comb begin
    step_op    = OP_WRITE;
    step_start = 1'b0;
    step_stop  = 1'b0;
    step_data  = '0;
    case (step)
      2'd0: begin
        step_start = 1'b1;
        step_data  = DATA_WIDTH'({dev_q, 1'b0});
      end
      2'd1: step_data = reg_q;
      2'd2: begin
        if (rnw_q) begin
          step_start = 1'b1;
          step_data  = DATA_WIDTH'({dev_q, 1'b1});
        end else begin
          step_stop = 1'b1;
          step_data = wdata_q;
        end
      end
      default: begin
        step_op   = OP_READ;
        step_stop = 1'b1;
      end
    endcase
  end

  assign last_step = rnw_q ? (step == 2'd3) : (step == 2'd2);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + TMO_WIDTH'(1);
  assign tmo_hit   = (timeout_i != '0) && (cnt_inc >= timeout_i);

  always_comb begin
    state_nxt     = state;
    step_nxt      = step;
    err_nxt       = err_q;
    rdata_nxt     = rdata_q;
    cnt_nxt       = cnt_q;
    accept        = 1'b0;
    m_cmd_valid_o = 1'b0;
    m_cmd_op_o    = OP_WRITE;
    m_cmd_start_o = 1'b0;
    m_cmd_stop_o  = 1'b0;
    m_cmd_data_o  = '0;
    case (state)
      IDLE: begin
        if (ready_q && req_valid_i) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
          step_nxt  = 2'd0;
          err_nxt   = ERR_OK;
          rdata_nxt = '0;
        end
      end
      ISSUE: begin
        m_cmd_valid_o = 1'b1;
        m_cmd_op_o    = step_op;
        m_cmd_start_o = step_start;
        m_cmd_stop_o  = step_stop;
        m_cmd_data_o  = step_data;
        if (m_cmd_ready_i) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        cnt_nxt = cnt_inc;
        if (m_done_i) begin
          if (step_op == OP_WRITE && !m_ack_i) begin
            err_nxt = ERR_NACK;
            // a NACK on the last byte already has STOP queued with it
            state_nxt = last_step ? RESP : ABORT;
          end else begin
            if (step_op == OP_READ) rdata_nxt = m_rdata_i;
            if (last_step) begin
              state_nxt = RESP;
            end else begin
              step_nxt  = step + 2'd1;
              state_nxt = ISSUE;
            end
          end
        end else if (tmo_hit) begin
          err_nxt   = ERR_TMO;
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        m_cmd_valid_o = 1'b1;
        m_cmd_op_o    = OP_STOP;
        m_cmd_stop_o  = 1'b1;
        if (m_cmd_ready_i) begin
          state_nxt = ABORT_WAIT;
          cnt_nxt   = '0;
        end
      end
      ABORT_WAIT: begin
        cnt_nxt = cnt_inc;
        if (m_done_i || tmo_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state       <= IDLE;
      step        <= 2'd0;
      rnw_q       <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_err_q   <= ERR_OK;
      rsp_rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      cnt_q   <= cnt_nxt;
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        rnw_q       <= req_rnw_i;
        dev_q       <= req_dev_addr_i;
        reg_q       <= req_reg_addr_i;
        wdata_q     <= req_wdata_i;
        rsp_err_q   <= ERR_OK;
        rsp_rdata_q <= '0;
      end else if (state_nxt == RESP && state != RESP) begin
        rsp_err_q   <= err_nxt;
        rsp_rdata_q <= (err_nxt == ERR_OK && rnw_q) ? rdata_nxt : '0;
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state == RESP);
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: directed scenarios plus randomized transactions checked against
// a byte-list reference model of the expected command stream and response.
module tb_i2c_reg_seq;

  logic        clk = 1'b0;
  logic        s_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rnw;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [7:0]  req_wdata;
  logic [15:0] timeout;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [1:0]  m_cmd_op;
  logic        m_cmd_start;
  logic        m_cmd_stop;
  logic [7:0]  m_cmd_data;
  logic        m_done;
  logic        m_ack;
  logic [7:0]  m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_reg_seq dut (
    .clk_i          (clk),
    .s_rst_i        (s_rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_rnw_i      (req_rnw),
    .req_dev_addr_i (req_dev),
    .req_reg_addr_i (req_reg),
    .req_wdata_i    (req_wdata),
    .timeout_i      (timeout),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .m_cmd_valid_o  (m_cmd_valid),
    .m_cmd_ready_i  (m_cmd_ready),
    .m_cmd_op_o     (m_cmd_op),
    .m_cmd_start_o  (m_cmd_start),
    .m_cmd_stop_o   (m_cmd_stop),
    .m_cmd_data_o   (m_cmd_data),
    .m_done_i       (m_done),
    .m_ack_i        (m_ack),
    .m_rdata_i      (m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // command word {op, start, stop, data}; data only matters for WRITE bytes
  function automatic logic [11:0] cmd_key(input logic [11:0] c);
    return (c[11:10] == 2'd0) ? c : {c[11:8], 8'h00};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_cmd"}, 32'({m_cmd_valid, m_cmd_op, m_cmd_start, m_cmd_stop, m_cmd_data}), 32'd0);
  endtask

  task automatic run_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd, input logic [7:0] rd, input int nack_at,
                         input int hang_at, input int stall_at, input int rst_at,
                         input logic [15:0] tmo, input int lat, input logic hold);
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [11:0] cur, held;
    logic [1:0]  exp_err, got_err;
    logic [7:0]  exp_rd, got_rd;
    logic        last_read;
    bit          expect_rsp, got_rsp, fin, ready_bad, stall_bad, in_hang, rst_pending;
    int          n, idx, cur_idx, stall, done_cd, wait_cnt, hang_len, budget, cyc;

    // reference model: ordered byte list, truncated by the first failing byte
    exp_err = 2'd0;
    expect_rsp = 1'b1;
    n = rnw ? 4 : 3;
    for (int i = 0; i < n; i++) begin
      case (i)
        0: exp_q.push_back({2'd0, 1'b1, 1'b0, dev, 1'b0});
        1: exp_q.push_back({2'd0, 1'b0, 1'b0, ra});
        2: exp_q.push_back(rnw ? {2'd0, 1'b1, 1'b0, dev, 1'b1} : {2'd0, 1'b0, 1'b1, wd});
        default: exp_q.push_back({2'd1, 1'b0, 1'b1, 8'h00});
      endcase
      if (i == rst_at) begin
        expect_rsp = 1'b0;
        break;
      end
      if (i == hang_at) begin
        exp_err = 2'd2;
        exp_q.push_back({2'd2, 1'b0, 1'b1, 8'h00});
        break;
      end
      if (i == nack_at && !(rnw && i == 3)) begin
        exp_err = 2'd1;
        if (i != n - 1) exp_q.push_back({2'd2, 1'b0, 1'b1, 8'h00});
        break;
      end
    end
    exp_rd = (exp_err == 2'd0 && rnw) ? rd : 8'h00;

    req_rnw = rnw; req_dev = dev; req_reg = ra; req_wdata = wd; timeout = tmo;
    req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = hold;
    chk("first_cmd_valid", 32'(m_cmd_valid), 32'd1);

    idx = 0; cur_idx = 0; stall = 0; done_cd = -1; wait_cnt = 0; hang_len = -1;
    in_hang = 0; fin = 0; got_rsp = 0; ready_bad = 0; stall_bad = 0; rst_pending = 0;
    last_read = 0; held = '0; got_err = '0; got_rd = '0;
    budget = 400;
    while (!fin && budget > 0) begin
      budget--;
      m_done = 1'b0; m_ack = 1'b1; m_cmd_ready = 1'b0;
      if (rsp_valid) begin
        got_rsp = 1; got_err = rsp_err; got_rd = rsp_rdata;
        if (req_ready) ready_bad = 1;
        fin = 1;
      end else if (rst_pending) begin
        s_rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        s_rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
        fin = 1;
      end else begin
        if (req_ready) ready_bad = 1;
        if (m_cmd_valid) begin
          cur = {m_cmd_op, m_cmd_start, m_cmd_stop, m_cmd_data};
          if (in_hang) begin
            hang_len = wait_cnt;
            in_hang = 0;
          end
          if (idx == stall_at && stall < 5) begin
            if (stall > 0 && cur !== held) stall_bad = 1;
            held = cur;
            stall++;
            m_done = 1'b1;  // stray done while not waiting must be ignored
            m_ack = 1'b0;
          end else begin
            if (idx == stall_at && cur !== held) stall_bad = 1;
            m_cmd_ready = 1'b1;
            got_q.push_back(cur);
            cur_idx = idx;
            last_read = (cur[11:10] == 2'd1);
            idx++;
            if (cur_idx == hang_at) begin
              in_hang = 1;
              wait_cnt = 0;
            end else if (cur_idx == rst_at) begin
              rst_pending = 1;
            end else begin
              done_cd = lat;
            end
          end
        end else begin
          if (in_hang) wait_cnt++;
          if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) begin
              m_done = 1'b1;
              m_ack = (cur_idx != nack_at);
              m_rdata = last_read ? rd : ~rd;
              done_cd = -1;
            end
          end
        end
      end
      if (!fin) @(negedge clk);
    end
    m_done = 1'b0; m_cmd_ready = 1'b0;

    chk("txn_finished", 32'(fin), 32'd1);
    chk("rsp_seen", 32'(got_rsp), 32'(expect_rsp));
    chk("cmd_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("cmd%0d", i), 32'(cmd_key(got_q[i])), 32'(cmd_key(exp_q[i])));
    chk("req_ready_busy", 32'(ready_bad), 32'd0);
    if (stall_at >= 0 && stall_at < exp_q.size()) chk("stall_stable", 32'(stall_bad), 32'd0);
    if (hang_at >= 0) chk("wait_len", 32'(hang_len), 32'(tmo));
    if (got_rsp) begin
      chk("rsp_err", 32'(got_err), 32'(exp_err));
      chk("rsp_rdata", 32'(got_rd), 32'(exp_rd));
      @(negedge clk);
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      chk("rsp_err_hold", 32'(rsp_err), 32'(exp_err));
      chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(exp_rd));
      chk("idle_ready", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    s_rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_dev = '0; req_reg = '0;
    req_wdata = '0; timeout = '0; m_cmd_ready = 1'b0; m_done = 1'b0; m_ack = 1'b1;
    m_rdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    s_rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // write with ACKs, read returning 0x3C
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, -1, -1, 16'd0, 3, 1'b0);
    run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, -1, -1, -1, 16'd0, 2, 1'b0);
    // NACK on the address byte
    run_txn(1'b0, 7'h50, 8'h10, 8'h5A, 8'h00, 0, -1, -1, -1, 16'd0, 1, 1'b0);
    // NACK on the last write byte: no extra STOP
    run_txn(1'b0, 7'h1B, 8'h04, 8'h77, 8'h00, 2, -1, -1, -1, 16'd0, 2, 1'b0);
    // master silent after the register byte
    run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h99, -1, 1, -1, -1, 16'd20, 1, 1'b0);
    // ready stalled on s1 while a second request is already waiting
    run_txn(1'b0, 7'h33, 8'h41, 8'hC3, 8'h00, -1, -1, 1, -1, 16'd40, 2, 1'b1);
    run_txn(1'b0, 7'h33, 8'h41, 8'hC3, 8'h00, -1, -1, -1, -1, 16'd40, 2, 1'b0);
    // reset while waiting on s2, then a normal read
    run_txn(1'b1, 7'h2A, 8'h80, 8'h00, 8'h11, -1, -1, -1, 2, 16'd0, 3, 1'b0);
    run_txn(1'b1, 7'h2A, 8'h81, 8'h00, 8'hE7, -1, -1, -1, -1, 16'd0, 3, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic r;
      int nb, lat, nk, hg, st;
      logic [15:0] tm;
      r   = 1'($urandom_range(1, 0));
      nb  = r ? 4 : 3;
      lat = 1 + int'($urandom_range(3, 0));
      nk  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
      hg  = (nk < 0 && $urandom_range(4, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
      st  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
      if (hg >= 0) tm = 16'(5 + $urandom_range(25, 0));
      else if ($urandom_range(1, 0) == 1) tm = 16'd0;
      else tm = 16'(lat + 1 + int'($urandom_range(20, 0)));
      run_txn(r, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              nk, hg, st, -1, tm, lat, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
